// File: rtl/nts_api_router_if.sv
// Host/target bus bundle for nts_api_router: the API request/response side and
// the one-hot internal target side, plus the unmapped-access counter.
interface nts_api_router_if #(
    parameter int NUM_TARGETS    = 5,
    parameter int ADDR_WIDTH     = 12,
    parameter int INT_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32
);
    logic                              i_api_cs;
    logic                              i_api_we;
    logic [ADDR_WIDTH-1:0]             i_api_address;
    logic [DATA_WIDTH-1:0]             i_api_write_data;
    logic                              o_api_ready;
    logic                              o_api_ack;
    logic [DATA_WIDTH-1:0]             o_api_read_data;
    logic                              o_api_unmapped;
    logic [NUM_TARGETS-1:0]            o_int_cs;
    logic                              o_int_we;
    logic [INT_ADDR_WIDTH-1:0]         o_int_address;
    logic [DATA_WIDTH-1:0]             o_int_write_data;
    logic [NUM_TARGETS*DATA_WIDTH-1:0] i_int_read_data;
    logic [15:0]                       o_unmapped_count;
    logic                              i_unmapped_count_clear;

    modport slave (
        input  i_api_cs, i_api_we, i_api_address, i_api_write_data,
        input  i_int_read_data, i_unmapped_count_clear,
        output o_api_ready, o_api_ack, o_api_read_data, o_api_unmapped,
        output o_int_cs, o_int_we, o_int_address, o_int_write_data,
        output o_unmapped_count
    );

    modport master (
        output i_api_cs, i_api_we, i_api_address, i_api_write_data,
        output i_int_read_data, i_unmapped_count_clear,
        input  o_api_ready, o_api_ack, o_api_read_data, o_api_unmapped,
        input  o_int_cs, o_int_we, o_int_address, o_int_write_data,
        input  o_unmapped_count
    );
endinterface

// File: rtl/nts_api_router.sv
// Registered API router: decodes one request against NUM_TARGETS windows, issues a
// one-cycle chip-select, waits READ_LATENCY, acks. Optional: NTS_API_ROUTER_UNMAPPED_COUNT_EN.
module nts_api_router #(
    parameter int NUM_TARGETS    = 5,
    parameter int ADDR_WIDTH     = 12,
    parameter int INT_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_BASE =
        {12'h180, 12'h080, 12'h020, 12'h010, 12'h000},
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_STOP =
        {12'h1FF, 12'h17F, 12'h03F, 12'h01F, 12'h009},
    parameter int READ_LATENCY   = 1
) (
    input  logic             i_clk,
    input  logic             i_areset,
    nts_api_router_if.slave  bus
);
    localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam logic [2:0] LAT_INIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic                      ack_q, ack_d;
    logic                      unm_q, unm_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [NUM_TARGETS-1:0]    int_cs_q, int_cs_d;
    logic                      int_we_q, int_we_d;
    logic [INT_ADDR_WIDTH-1:0] int_addr_q, int_addr_d;
    logic [DATA_WIDTH-1:0]     int_wdata_q, int_wdata_d;
    logic                      hit_q, hit_d;
    logic [TW-1:0]             tgt_q, tgt_d;
    logic [2:0]                cnt_q, cnt_d;

    logic                      dec_hit;
    logic [TW-1:0]             dec_tgt;
    logic [NUM_TARGETS-1:0]    dec_cs;
    logic [ADDR_WIDTH-1:0]     dec_base;
    logic [DATA_WIDTH-1:0]     rd_sel;

    // Descending scan so the lowest-numbered overlapping window wins.
    always_comb begin
        dec_hit  = 1'b0;
        dec_tgt  = '0;
        dec_cs   = '0;
        dec_base = '0;
        for (int k = NUM_TARGETS - 1; k >= 0; k--) begin
            if (bus.i_api_address >= TARGET_BASE[k*ADDR_WIDTH +: ADDR_WIDTH] &&
                bus.i_api_address <= TARGET_STOP[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_hit   = 1'b1;
                dec_tgt   = TW'(k);
                dec_cs    = '0;
                dec_cs[k] = 1'b1;
                dec_base  = TARGET_BASE[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (tgt_q == TW'(k)) rd_sel = bus.i_int_read_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            unm_q       <= 1'b0;
            rdata_q     <= '0;
            int_cs_q    <= '0;
            int_we_q    <= 1'b0;
            int_addr_q  <= '0;
            int_wdata_q <= '0;
            hit_q       <= 1'b0;
            tgt_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            unm_q       <= unm_d;
            rdata_q     <= rdata_d;
            int_cs_q    <= int_cs_d;
            int_we_q    <= int_we_d;
            int_addr_q  <= int_addr_d;
            int_wdata_q <= int_wdata_d;
            hit_q       <= hit_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.i_api_cs) state_d = ISSUE;
            ISSUE: state_d = (int_we_q || !hit_q || READ_LATENCY == 0) ? DONE : WAIT;
            WAIT:  if (cnt_q == 3'd0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from state_d so every port is a flop.
    always_comb begin
        ready_d     = (state_d == IDLE);
        ack_d       = (state_d == DONE);
        unm_d       = (state_d == DONE) && !hit_q;
        rdata_d     = rdata_q;
        int_cs_d    = '0;
        int_we_d    = int_we_q;
        int_addr_d  = int_addr_q;
        int_wdata_d = int_wdata_q;
        hit_d       = hit_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_api_cs) begin
                    int_cs_d    = dec_cs;
                    int_we_d    = bus.i_api_we;
                    int_addr_d  = INT_ADDR_WIDTH'(bus.i_api_address - dec_base);
                    int_wdata_d = bus.i_api_write_data;
                    hit_d       = dec_hit;
                    tgt_d       = dec_tgt;
                end
            end
            ISSUE: begin
                cnt_d = LAT_INIT;
                if (!int_we_q && !hit_q)
                    rdata_d = '0;
                else if (!int_we_q && READ_LATENCY == 0)
                    rdata_d = rd_sel;
            end
            WAIT: begin
                if (cnt_q == 3'd0) rdata_d = rd_sel;
                else               cnt_d = cnt_q - 3'd1;
            end
            default: ;
        endcase
    end

    assign bus.o_api_ready      = ready_q;
    assign bus.o_api_ack        = ack_q;
    assign bus.o_api_unmapped   = unm_q;
    assign bus.o_api_read_data  = rdata_q;
    assign bus.o_int_cs         = int_cs_q;
    assign bus.o_int_we         = int_we_q;
    assign bus.o_int_address    = int_addr_q;
    assign bus.o_int_write_data = int_wdata_q;

`ifdef NTS_API_ROUTER_UNMAPPED_COUNT_EN
    logic [15:0] ucnt_q;

    // Clear has priority; the count saturates rather than wrapping.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset)
            ucnt_q <= '0;
        else if (bus.i_unmapped_count_clear)
            ucnt_q <= '0;
        else if (state_q == DONE && !hit_q && ucnt_q != 16'hFFFF)
            ucnt_q <= ucnt_q + 16'd1;
    end

    assign bus.o_unmapped_count = ucnt_q;
`else
    logic unused_clear;
    assign unused_clear         = bus.i_unmapped_count_clear;
    assign bus.o_unmapped_count = '0;
`endif
endmodule

// File: tb/tb_nts_api_router.sv
// Directed self-checking bench for nts_api_router: default DUT (latency 1) plus a
// READ_LATENCY=3 instance for the capture-window check.
module tb_nts_api_router;
    logic i_clk = 1'b0;
    logic i_areset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 i_clk = ~i_clk;

    nts_api_router_if #(.NUM_TARGETS(5), .ADDR_WIDTH(12), .INT_ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();
    nts_api_router_if #(.NUM_TARGETS(5), .ADDR_WIDTH(12), .INT_ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();

    nts_api_router u0 (.i_clk(i_clk), .i_areset(i_areset), .bus(bus0));
    nts_api_router #(.READ_LATENCY(3)) u3 (.i_clk(i_clk), .i_areset(i_areset), .bus(bus3));

`ifdef NTS_API_ROUTER_UNMAPPED_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        step(); step();
        total++; if (bus0.o_api_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus0.o_api_ready); end
        total++; if (bus0.o_api_ack !== 1'b0 || bus0.o_api_unmapped !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b%b exp=00", bus0.o_api_ack, bus0.o_api_unmapped); end
        total++; if (bus0.o_int_cs !== 5'b0 || bus0.o_int_we !== 1'b0) begin bad++; $display("FAIL rst_cs got=%b/%b exp=0", bus0.o_int_cs, bus0.o_int_we); end
        total++; if (bus0.o_int_address !== 8'h00 || bus0.o_int_write_data !== 32'h0 || bus0.o_api_read_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", bus0.o_int_address, bus0.o_int_write_data, bus0.o_api_read_data); end
        total++; if (bus0.o_unmapped_count !== 16'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", bus0.o_unmapped_count); end
        i_areset = 1'b0;
        step();
        total++; if (bus0.o_api_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got=%b exp=1", bus0.o_api_ready); end
    endtask

    task automatic test_read();
        bus0.i_api_cs = 1'b1; bus0.i_api_we = 1'b0; bus0.i_api_address = 12'h015;
        step(); bus0.i_api_cs = 1'b0;
        total++; if (bus0.o_int_cs !== 5'b00010) begin bad++; $display("FAIL rd_cs got=%b exp=00010", bus0.o_int_cs); end
        total++; if (bus0.o_int_address !== 8'h05 || bus0.o_int_we !== 1'b0) begin bad++; $display("FAIL rd_addr got=%h/%b exp=05/0", bus0.o_int_address, bus0.o_int_we); end
        total++; if (bus0.o_api_ready !== 1'b0) begin bad++; $display("FAIL rd_ready_low got=%b exp=0", bus0.o_api_ready); end
        step();
        total++; if (bus0.o_api_ack !== 1'b0 || bus0.o_int_cs !== 5'b0) begin bad++; $display("FAIL rd_t2 got=ack%b cs%b exp=0", bus0.o_api_ack, bus0.o_int_cs); end
        step();
        total++; if (bus0.o_api_ack !== 1'b1 || bus0.o_api_unmapped !== 1'b0) begin bad++; $display("FAIL rd_ack got=%b%b exp=10", bus0.o_api_ack, bus0.o_api_unmapped); end
        total++; if (bus0.o_api_read_data !== 32'hCAFE0001) begin bad++; $display("FAIL rd_data got=%h exp=cafe0001", bus0.o_api_read_data); end
        step();
        total++; if (bus0.o_api_ready !== 1'b1 || bus0.o_api_ack !== 1'b0) begin bad++; $display("FAIL rd_after got=rdy%b ack%b exp=10", bus0.o_api_ready, bus0.o_api_ack); end
    endtask

    task automatic test_write();
        bus0.i_api_cs = 1'b1; bus0.i_api_we = 1'b1; bus0.i_api_address = 12'h090; bus0.i_api_write_data = 32'h12345678;
        step(); bus0.i_api_cs = 1'b0;
        total++; if (bus0.o_int_cs !== 5'b01000 || bus0.o_int_we !== 1'b1) begin bad++; $display("FAIL wr_cs got=%b/%b exp=01000/1", bus0.o_int_cs, bus0.o_int_we); end
        total++; if (bus0.o_int_address !== 8'h10 || bus0.o_int_write_data !== 32'h12345678) begin bad++; $display("FAIL wr_bus got=%h/%h exp=10/12345678", bus0.o_int_address, bus0.o_int_write_data); end
        step();
        total++; if (bus0.o_api_ack !== 1'b1 || bus0.o_api_unmapped !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b%b exp=10", bus0.o_api_ack, bus0.o_api_unmapped); end
        total++; if (bus0.o_api_read_data !== 32'hCAFE0001) begin bad++; $display("FAIL wr_rdata_held got=%h exp=cafe0001", bus0.o_api_read_data); end
        total++; if (bus0.o_int_we !== 1'b1 || bus0.o_int_address !== 8'h10) begin bad++; $display("FAIL wr_hold got=%b/%h exp=1/10", bus0.o_int_we, bus0.o_int_address); end
        step();
        total++; if (bus0.o_api_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", bus0.o_api_ready); end
    endtask

    task automatic test_unmapped();
        logic [15:0] exp_cnt;
        bus0.i_api_cs = 1'b1; bus0.i_api_we = 1'b0; bus0.i_api_address = 12'h050;
        step(); bus0.i_api_cs = 1'b0;
        total++; if (bus0.o_int_cs !== 5'b0) begin bad++; $display("FAIL um_cs got=%b exp=00000", bus0.o_int_cs); end
        step();
        total++; if (bus0.o_api_ack !== 1'b1 || bus0.o_api_unmapped !== 1'b1) begin bad++; $display("FAIL um_ack got=%b%b exp=11", bus0.o_api_ack, bus0.o_api_unmapped); end
        total++; if (bus0.o_api_read_data !== 32'h0) begin bad++; $display("FAIL um_rdata got=%h exp=0", bus0.o_api_read_data); end
        step();
        exp_cnt = CNT_EN ? 16'd1 : 16'd0;
        total++; if (bus0.o_unmapped_count !== exp_cnt) begin bad++; $display("FAIL um_count got=%h exp=%h", bus0.o_unmapped_count, exp_cnt); end
        total++; if (bus0.o_api_unmapped !== 1'b0 || bus0.o_api_ready !== 1'b1) begin bad++; $display("FAIL um_after got=um%b rdy%b exp=01", bus0.o_api_unmapped, bus0.o_api_ready); end
        // Second unmapped access with clear asserted in its ack cycle.
        bus0.i_api_cs = 1'b1; bus0.i_api_we = 1'b1; bus0.i_api_address = 12'h00A;
        step(); bus0.i_api_cs = 1'b0;
        step();
        total++; if (bus0.o_api_unmapped !== 1'b1) begin bad++; $display("FAIL um_wr_flag got=%b exp=1", bus0.o_api_unmapped); end
        bus0.i_unmapped_count_clear = 1'b1;
        step();
        bus0.i_unmapped_count_clear = 1'b0;
        total++; if (bus0.o_unmapped_count !== 16'h0) begin bad++; $display("FAIL um_clear got=%h exp=0", bus0.o_unmapped_count); end
    endtask

    task automatic test_decode_edges();
        logic [11:0] addrs [7] = '{12'h000, 12'h009, 12'h00F, 12'h01F, 12'h020, 12'h1FF, 12'h200};
        logic [4:0]  cs    [7] = '{5'b00001, 5'b00001, 5'b00000, 5'b00010, 5'b00100, 5'b10000, 5'b00000};
        logic [7:0]  ia    [7] = '{8'h00, 8'h09, 8'h00, 8'h0F, 8'h00, 8'h7F, 8'h00};
        for (int i = 0; i < 7; i++) begin
            bus0.i_api_cs = 1'b1; bus0.i_api_we = 1'b1; bus0.i_api_address = addrs[i];
            step(); bus0.i_api_cs = 1'b0;
            total++; if (bus0.o_int_cs !== cs[i]) begin bad++; $display("FAIL dec_cs[%0d] got=%b exp=%b", i, bus0.o_int_cs, cs[i]); end
            if (cs[i] != 5'b0) begin
                total++; if (bus0.o_int_address !== ia[i]) begin bad++; $display("FAIL dec_addr[%0d] got=%h exp=%h", i, bus0.o_int_address, ia[i]); end
            end
            step();
            total++; if (bus0.o_api_unmapped !== (cs[i] == 5'b0) || bus0.o_api_ack !== 1'b1) begin bad++; $display("FAIL dec_um[%0d] got=%b%b exp=1%b", i, bus0.o_api_ack, bus0.o_api_unmapped, cs[i] == 5'b0); end
            step();
        end
    endtask

    task automatic test_latency3();
        bus3.i_api_cs = 1'b1; bus3.i_api_we = 1'b0; bus3.i_api_address = 12'h1FF;
        step(); bus3.i_api_cs = 1'b0;
        total++; if (bus3.o_int_cs !== 5'b10000 || bus3.o_int_address !== 8'h7F) begin bad++; $display("FAIL l3_issue got=%b/%h exp=10000/7f", bus3.o_int_cs, bus3.o_int_address); end
        step();
        step(); bus3.i_int_read_data[4*32 +: 32] = 32'hAAAA0003;
        total++; if (bus3.o_api_ack !== 1'b0) begin bad++; $display("FAIL l3_t3_ack got=%b exp=0", bus3.o_api_ack); end
        step(); bus3.i_int_read_data[4*32 +: 32] = 32'hBBBB0004;
        total++; if (bus3.o_api_ack !== 1'b0) begin bad++; $display("FAIL l3_t4_ack got=%b exp=0", bus3.o_api_ack); end
        step();
        total++; if (bus3.o_api_ack !== 1'b1 || bus3.o_api_read_data !== 32'hBBBB0004) begin bad++; $display("FAIL l3_ack got=%b/%h exp=1/bbbb0004", bus3.o_api_ack, bus3.o_api_read_data); end
        step();
        total++; if (bus3.o_api_ready !== 1'b1) begin bad++; $display("FAIL l3_ready got=%b exp=1", bus3.o_api_ready); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_cs;
        bus0.i_api_cs = 1'b1; bus0.i_api_we = 1'b0; bus0.i_api_address = 12'h015;
        for (int n = 1; n <= 12; n++) begin
            step();
            exp_cs = (n % 4 == 1) ? 5'b00010 : 5'b00000;
            total++; if (bus0.o_int_cs !== exp_cs) begin bad++; $display("FAIL b2b_cs[%0d] got=%b exp=%b", n, bus0.o_int_cs, exp_cs); end
            total++; if (bus0.o_api_ack !== (n % 4 == 3) || bus0.o_api_ready !== (n % 4 == 0)) begin bad++; $display("FAIL b2b_hs[%0d] got=ack%b rdy%b exp=ack%b rdy%b", n, bus0.o_api_ack, bus0.o_api_ready, n % 4 == 3, n % 4 == 0); end
        end
        bus0.i_api_cs = 1'b0;
        step();
    endtask

    task automatic test_reset_wait();
        bus0.i_api_cs = 1'b1; bus0.i_api_we = 1'b0; bus0.i_api_address = 12'h015;
        step(); bus0.i_api_cs = 1'b0;
        step();
        #2 i_areset = 1'b1;
        #1;
        total++; if (bus0.o_api_ready !== 1'b0 || bus0.o_api_ack !== 1'b0 || bus0.o_int_cs !== 5'b0) begin bad++; $display("FAIL rw_async got=rdy%b ack%b cs%b exp=0", bus0.o_api_ready, bus0.o_api_ack, bus0.o_int_cs); end
        total++; if (bus0.o_api_read_data !== 32'h0 || bus0.o_int_address !== 8'h0) begin bad++; $display("FAIL rw_async_data got=%h/%h exp=0", bus0.o_api_read_data, bus0.o_int_address); end
        step(); step();
        i_areset = 1'b0;
        step();
        total++; if (bus0.o_api_ready !== 1'b1 || bus0.o_api_ack !== 1'b0) begin bad++; $display("FAIL rw_release got=rdy%b ack%b exp=10", bus0.o_api_ready, bus0.o_api_ack); end
        bus0.i_api_cs = 1'b1;
        step(); bus0.i_api_cs = 1'b0;
        total++; if (bus0.o_int_cs !== 5'b00010) begin bad++; $display("FAIL rw_next_cs got=%b exp=00010", bus0.o_int_cs); end
        step(); step();
        total++; if (bus0.o_api_ack !== 1'b1 || bus0.o_api_read_data !== 32'hCAFE0001) begin bad++; $display("FAIL rw_next_ack got=%b/%h exp=1/cafe0001", bus0.o_api_ack, bus0.o_api_read_data); end
        step();
    endtask

    initial begin
        bus0.i_api_cs = 1'b0; bus0.i_api_we = 1'b0; bus0.i_api_address = '0; bus0.i_api_write_data = '0;
        bus0.i_unmapped_count_clear = 1'b0;
        bus0.i_int_read_data = {32'h44440004, 32'h33330003, 32'h22220002, 32'hCAFE0001, 32'h11110000};
        bus3.i_api_cs = 1'b0; bus3.i_api_we = 1'b0; bus3.i_api_address = '0; bus3.i_api_write_data = '0;
        bus3.i_unmapped_count_clear = 1'b0;
        bus3.i_int_read_data = {32'h99990004, 32'h0, 32'h0, 32'h0, 32'h0};
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_decode_edges();
        test_latency3();
        test_back_to_back();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
